// File: rtl/spr_pkg.sv
// Shared definitions for the SPR gamma/de-gamma segment search.
// This file holds the default widths, the reset breakpoint function and the lane slicing helper.
package spr_pkg;

  localparam int DW_DEF       = 11;
  localparam int SEG_LOG2_DEF = 5;

  // Reset breakpoint k: evenly spaced levels, with the last entry pinned to full scale.
  function automatic logic [31:0] default_level(input int k, input int dw, input int seg_log2);
    if (k < (1 << seg_log2)) begin
      return 32'(k) << (dw - seg_log2);
    end
    return (32'd1 << dw) - 32'd1;
  endfunction

  function automatic int lane_lsb(input int c, input int w);
    return c * w;
  endfunction

endpackage

// File: rtl/search_idx_lane.sv
// Per-channel datapath in two stages.
// Stage 1 compares the pixel against the breakpoints and encodes the segment index; stage 2 looks up the levels and forms offset and span.
module search_idx_lane
  import spr_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int SEG_LOG2 = SEG_LOG2_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en1_i,
  input  logic                             en2_i,
  input  logic [DW-1:0]                    pix_i,
  input  logic [((1<<SEG_LOG2)+1)*DW-1:0]  table_i,
  output logic [SEG_LOG2-1:0]              idx_o,
  output logic [DW-1:0]                    pixel_o,
  output logic [DW-1:0]                    low_o,
  output logic [DW-1:0]                    high_o,
  output logic [DW-1:0]                    offset_o,
  output logic [DW-1:0]                    span_o
);

  localparam int SEG = 1 << SEG_LOG2;

  logic [DW-1:0]       lvl [SEG+1];
  logic [SEG_LOG2-1:0] idx_d, idx_q;
  logic [DW-1:0]       pix_q;
  logic [SEG_LOG2:0]   idx_hi;
  logic [DW-1:0]       low_d, high_d, offset_d, span_d;
  logic [SEG_LOG2-1:0] idx2_q;
  logic [DW-1:0]       pix2_q, low_q, high_q, offset_q, span_q;

  for (genvar k = 0; k <= SEG; k++) begin : g_lvl
    assign lvl[k] = table_i[lane_lsb(k, DW) +: DW];
  end

  // Highest set compare bit wins, so a non-monotonic table still resolves deterministically.
  always_comb begin
    idx_d = '0;
    for (int k = 0; k < SEG; k++) begin
      if (pix_i >= lvl[k]) idx_d = SEG_LOG2'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      pix_q <= '0;
    end else begin
      idx_q <= en1_i ? idx_d : '0;
      pix_q <= en1_i ? pix_i : '0;
    end
  end

  assign idx_hi = {1'b0, idx_q} + (SEG_LOG2+1)'(1);

  always_comb begin
    low_d    = lvl[{1'b0, idx_q}];
    high_d   = lvl[idx_hi];
    offset_d = (pix_q >= low_d) ? pix_q - low_d : '0;
    span_d   = (high_d >= low_d) ? high_d - low_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx2_q   <= '0;
      pix2_q   <= '0;
      low_q    <= '0;
      high_q   <= '0;
      offset_q <= '0;
      span_q   <= '0;
    end else if (en2_i) begin
      idx2_q   <= idx_q;
      pix2_q   <= pix_q;
      low_q    <= low_d;
      high_q   <= high_d;
      offset_q <= offset_d;
      span_q   <= span_d;
    end else begin
      idx2_q   <= '0;
      pix2_q   <= '0;
      low_q    <= '0;
      high_q   <= '0;
      offset_q <= '0;
      span_q   <= '0;
    end
  end

  assign idx_o    = idx2_q;
  assign pixel_o  = pix2_q;
  assign low_o    = low_q;
  assign high_o   = high_q;
  assign offset_o = offset_q;
  assign span_o   = span_q;

endmodule

// File: rtl/search_idx_pipe.sv
// Multi-channel piecewise-linear segment search with a double-buffered breakpoint table.
// Shadow edits go live only on a vsync falling edge after a commit request.
module search_idx_pipe
  import spr_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int SEG_LOG2 = SEG_LOG2_DEF,
  parameter int CH       = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_hs,
  input  logic                   i_vs,
  input  logic [CH*DW-1:0]       i_pix,
  input  logic                   cfg_we,
  input  logic [SEG_LOG2:0]      cfg_addr,
  input  logic [DW-1:0]          cfg_wdata,
  input  logic                   cfg_commit,
  output logic                   cfg_pending,
  output logic                   o_hs,
  output logic                   o_vs,
  output logic [CH*SEG_LOG2-1:0] o_idx,
  output logic [CH*DW-1:0]       o_pixel,
  output logic [CH*DW-1:0]       o_low,
  output logic [CH*DW-1:0]       o_high,
  output logic [CH*DW-1:0]       o_offset,
  output logic [CH*DW-1:0]       o_span
);

  localparam int SEG = 1 << SEG_LOG2;

  logic [DW-1:0]          shadow_q [SEG+1];
  logic [DW-1:0]          active_q [SEG+1];
  logic [(SEG+1)*DW-1:0]  table_flat;
  logic                   hs1_q, vs1_q, hs2_q, vs2_q;
  logic                   pending_q, pending_d;
  logic                   copy_evt;
  logic                   wr_ok;
  logic                   en1, en2;

  assign copy_evt = vs1_q & ~i_vs & pending_q;
  assign wr_ok    = cfg_we && (cfg_addr <= (SEG_LOG2+1)'(SEG));

  // A commit on the copy cycle re-arms the request for the following blanking.
  always_comb begin
    pending_d = pending_q | cfg_commit;
    if (copy_evt) pending_d = cfg_commit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      hs2_q     <= 1'b0;
      vs2_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      hs1_q     <= i_hs;
      vs1_q     <= i_vs;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      pending_q <= pending_d;
    end
  end

  // The copy reads shadow_q before this cycle's write lands, so same-cycle edits stay in the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= SEG; k++) begin
        shadow_q[k] <= DW'(default_level(k, DW, SEG_LOG2));
        active_q[k] <= DW'(default_level(k, DW, SEG_LOG2));
      end
    end else begin
      if (wr_ok) shadow_q[cfg_addr] <= cfg_wdata;
      if (copy_evt) begin
        for (int k = 0; k <= SEG; k++) active_q[k] <= shadow_q[k];
      end
    end
  end

  for (genvar k = 0; k <= SEG; k++) begin : g_flat
    assign table_flat[lane_lsb(k, DW) +: DW] = active_q[k];
  end

  assign en1 = i_hs & i_vs;
  assign en2 = hs1_q & vs1_q;

  for (genvar c = 0; c < CH; c++) begin : g_lane
    search_idx_lane #(
      .DW       (DW),
      .SEG_LOG2 (SEG_LOG2)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .en1_i    (en1),
      .en2_i    (en2),
      .pix_i    (i_pix[lane_lsb(c, DW) +: DW]),
      .table_i  (table_flat),
      .idx_o    (o_idx[lane_lsb(c, SEG_LOG2) +: SEG_LOG2]),
      .pixel_o  (o_pixel[lane_lsb(c, DW) +: DW]),
      .low_o    (o_low[lane_lsb(c, DW) +: DW]),
      .high_o   (o_high[lane_lsb(c, DW) +: DW]),
      .offset_o (o_offset[lane_lsb(c, DW) +: DW]),
      .span_o   (o_span[lane_lsb(c, DW) +: DW])
    );
  end

  assign cfg_pending = pending_q;
  assign o_hs        = hs2_q;
  assign o_vs        = vs2_q;

endmodule

// File: tb/tb_search_idx_pipe.sv
// Directed bench for search_idx_pipe: default table, commit timing, blanking, copy-cycle races and reset.
module tb_search_idx_pipe;

  localparam int DW = 11;
  localparam int SL = 5;
  localparam int CH = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_hs, i_vs;
  logic [CH*DW-1:0] i_pix;
  logic             cfg_we;
  logic [SL:0]      cfg_addr;
  logic [DW-1:0]    cfg_wdata;
  logic             cfg_commit;
  logic             cfg_pending;
  logic             o_hs, o_vs;
  logic [CH*SL-1:0] o_idx;
  logic [CH*DW-1:0] o_pixel, o_low, o_high, o_offset, o_span;

  int n_vec  = 0;
  int n_fail = 0;

  search_idx_pipe #(.DW(DW), .SEG_LOG2(SL), .CH(CH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_hs        (i_hs),
    .i_vs        (i_vs),
    .i_pix       (i_pix),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_commit  (cfg_commit),
    .cfg_pending (cfg_pending),
    .o_hs        (o_hs),
    .o_vs        (o_vs),
    .o_idx       (o_idx),
    .o_pixel     (o_pixel),
    .o_low       (o_low),
    .o_high      (o_high),
    .o_offset    (o_offset),
    .o_span      (o_span)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_lane(input string tag, input int c, input int idx, input int low,
                          input int high, input int off, input int span);
    chk($sformatf("%s.ch%0d.idx", tag, c),    64'(o_idx[c*SL +: SL]),    64'(idx));
    chk($sformatf("%s.ch%0d.low", tag, c),    64'(o_low[c*DW +: DW]),    64'(low));
    chk($sformatf("%s.ch%0d.high", tag, c),   64'(o_high[c*DW +: DW]),   64'(high));
    chk($sformatf("%s.ch%0d.offset", tag, c), 64'(o_offset[c*DW +: DW]), 64'(off));
    chk($sformatf("%s.ch%0d.span", tag, c),   64'(o_span[c*DW +: DW]),   64'(span));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".idx"},    64'(o_idx),    64'd0);
    chk({tag, ".pixel"},  64'(o_pixel),  64'd0);
    chk({tag, ".low"},    64'(o_low),    64'd0);
    chk({tag, ".high"},   64'(o_high),   64'd0);
    chk({tag, ".offset"}, 64'(o_offset), 64'd0);
    chk({tag, ".span"},   64'(o_span),   64'd0);
  endtask

  task automatic set_pix(input int p0, input int p1, input int p2);
    i_pix = {DW'(p2), DW'(p1), DW'(p0)};
  endtask

  task automatic wr(input int addr, input int data);
    cfg_we    = 1'b1;
    cfg_addr  = (SL+1)'(addr);
    cfg_wdata = DW'(data);
    tick();
    cfg_we    = 1'b0;
  endtask

  // Legacy 11-bit levels: 4-step low range, 46 at index 12, then coarser steps up to full scale.
  function automatic int legacy(input int k);
    if (k < 12)  return 4 * k;
    if (k == 12) return 46;
    if (k < 31)  return 62 + 110 * (k - 13);
    if (k == 31) return 2046;
    return 2047;
  endfunction

  initial begin
    rst_n = 1'b0; i_hs = 1'b0; i_vs = 1'b0; i_pix = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
    #1;
    chk("rst.pending", 64'(cfg_pending), 64'd0);
    chk("rst.hs", 64'(o_hs), 64'd0);
    chk("rst.vs", 64'(o_vs), 64'd0);
    chk_zero("rst");
    tick();
    rst_n = 1'b1;

    // Default table, low end.
    i_hs = 1'b1; i_vs = 1'b1; set_pix(63, 63, 63);
    tick(); tick();
    chk("t1.hs", 64'(o_hs), 64'd1);
    chk("t1.pixel0", 64'(o_pixel[0 +: DW]), 64'd63);
    for (int c = 0; c < CH; c++) chk_lane("t1", c, 0, 0, 64, 63, 64);

    // Default table, top boundaries.
    set_pix(2047, 1984, 1983);
    tick(); tick();
    chk_lane("t2", 0, 31, 1984, 2047, 63, 63);
    chk_lane("t2", 1, 31, 1984, 2047, 0, 63);
    chk_lane("t2", 2, 30, 1920, 1984, 63, 64);

    // Load legacy levels into the shadow mid-frame, then request a commit.
    set_pix(46, 46, 46);
    for (int k = 0; k <= 32; k++) wr(k, legacy(k));
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    chk("t3.pending_set", 64'(cfg_pending), 64'd1);
    tick(); tick();
    chk_lane("t3.pre", 0, 0, 0, 64, 46, 64);
    chk("t3.pending_hold", 64'(cfg_pending), 64'd1);
    i_vs = 1'b0; tick();
    chk("t3.pending_clr", 64'(cfg_pending), 64'd0);
    tick(); tick();
    chk("t3.vs_low", 64'(o_vs), 64'd0);
    chk_zero("t3.vblank");
    i_vs = 1'b1; tick(); tick();
    chk("t3.vs_high", 64'(o_vs), 64'd1);
    for (int c = 0; c < CH; c++) chk_lane("t3.post", c, 12, 46, 62, 0, 16);

    // Horizontal blanking for four input cycles.
    set_pix(100, 100, 100);
    tick(); tick();
    i_hs = 1'b0; tick();
    chk("t4.hs_pre", 64'(o_hs), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t4.hs_low%0d", i), 64'(o_hs), 64'd0);
      chk_zero($sformatf("t4.blank%0d", i));
      if (i == 2) i_hs = 1'b1;
    end
    tick();
    chk("t4.hs_back", 64'(o_hs), 64'd1);
    chk("t4.pixel", 64'(o_pixel[DW +: DW]), 64'd100);
    chk_lane("t4.resume", 1, 13, 62, 172, 38, 110);

    // Copy-cycle race: shadow[5]=22 is copied; the same-cycle write of 23 stays in the shadow.
    wr(5, 22);
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    i_vs = 1'b0; cfg_we = 1'b1; cfg_addr = 6'd5; cfg_wdata = 11'd23; cfg_commit = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    chk("t5.pending_rearm", 64'(cfg_pending), 64'd1);
    wr(33, 5);
    i_vs = 1'b1; set_pix(22, 4, 2047);
    tick(); tick(); tick();
    chk_lane("t5.copy1", 0, 5, 22, 24, 0, 2);
    chk_lane("t5.copy1", 1, 1, 4, 8, 0, 4);
    i_vs = 1'b0; tick();
    chk("t5.pending_clr", 64'(cfg_pending), 64'd0);
    i_vs = 1'b1; tick(); tick();
    chk_lane("t5.copy2", 0, 4, 16, 23, 6, 7);
    chk_lane("t5.copy2", 1, 1, 4, 8, 0, 4);
    chk_lane("t5.copy2", 2, 31, 2046, 2047, 1, 1);

    // Asynchronous reset mid-frame with a commit pending.
    set_pix(46, 46, 46);
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    tick(); tick();
    chk("t6.pending_pre", 64'(cfg_pending), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.pending", 64'(cfg_pending), 64'd0);
    chk("t6.hs", 64'(o_hs), 64'd0);
    chk("t6.vs", 64'(o_vs), 64'd0);
    chk_zero("t6.rst");
    tick();
    rst_n = 1'b1;
    set_pix(46, 1000, 2047);
    tick(); tick();
    chk_lane("t6.dflt", 0, 0, 0, 64, 46, 64);
    chk_lane("t6.dflt", 1, 15, 960, 1024, 40, 64);
    chk_lane("t6.dflt", 2, 31, 1984, 2047, 63, 63);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/search_idx_pipe.md
Name: search_idx_pipe

Overview:
Parametrised, multi-channel piecewise-linear segment search for the SPR gamma/de-gamma path. For each channel pixel it finds the segment index in a programmable breakpoint table and returns the segment's low/high levels, offset and span for the downstream interpolator. Breakpoints load through a double-buffered table, so a shadow table can be written mid-frame. The shadow is committed to the active table only at frame blanking. It replaces the fixed 11-bit, 32-level search with a 2-stage pipelined, sync-aligned block.

Parameters:
DW, 11, pixel and level width in bits
SEG_LOG2, 5, log2 of segment count; SEG = 2**SEG_LOG2 segments, SEG+1 breakpoints
CH, 3, number of independent pixel channels sharing one table

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_hs  in  1  horizontal sync; low = blanking
i_vs  in  1  vertical sync; low = blanking
i_pix  in  CH*DW  input pixels; channel c at bits [c*DW +: DW]
cfg_we  in  1  shadow table write strobe
cfg_addr  in  SEG_LOG2+1  breakpoint index 0..SEG
cfg_wdata  in  DW  breakpoint value
cfg_commit  in  1  pulse: request shadow-to-active copy
cfg_pending  out  1  commit requested, not yet applied
o_hs  out  1  i_hs delayed 2 cycles
o_vs  out  1  i_vs delayed 2 cycles
o_idx  out  CH*SEG_LOG2  segment index per channel
o_pixel  out  CH*DW  pixel delayed 2 cycles
o_low  out  CH*DW  level[idx]
o_high  out  CH*DW  level[idx+1]
o_offset  out  CH*DW  pixel - low, floored at 0
o_span  out  CH*DW  high - low, floored at 0

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0, including pipeline registers, o_hs/o_vs and cfg_pending.
  - Shadow and active tables load defaults: entry k = k << (DW-SEG_LOG2) for k<SEG; entry SEG = 2**DW-1. For DW=11 this gives 0,64,...,1984,2047.
- Table writes:
  - cfg_we=1 writes shadow[cfg_addr] <= cfg_wdata.
  - cfg_addr > SEG: write ignored.
  - The active table is never written directly.
- Commit:
  - cfg_commit=1 sets cfg_pending the next cycle. A repeat commit while pending has no further effect.
  - Copy event: i_vs falling edge (registered i_vs=1, current i_vs=0) with pending=1. On that cycle active <= shadow (whole table) and pending clears.
  - A cfg_we on the copy cycle updates shadow only; the copy uses the pre-write shadow.
  - cfg_commit on the copy cycle re-arms pending.
- Stage 1 (per channel):
  - mask[k] = (pix >= active[k]) for k=0..SEG-1.
  - idx = highest k with mask[k]=1; idx=0 if the mask is all zero.
  - The previous-value hold used when the mask is not thermometer-shaped is removed. A non-monotonic table still yields a deterministic highest-set-bit result.
  - Stage 1 registers idx, pix and the hs/vs bits.
- Stage 2:
  - low = active[idx], high = active[idx+1].
  - offset = (pix >= low) ? pix-low : 0.
  - span = (high >= low) ? high-low : 0.
  - All results are DW bits; the subtractions cannot wrap.
- Latency: exactly 2 cycles from i_pix/i_hs/i_vs to all outputs. Throughput 1 pixel/cycle/channel, no stall.
- Blanking: if the delayed hs or vs is 0 at a stage, that stage's data registers load 0. Result: o_idx, o_pixel, o_low, o_high, o_offset and o_span are all 0 whenever o_hs=0 or o_vs=0.
- Table-change timing: a copy takes effect for pixels sampled from the cycle after the copy. Pixels already in the pipe may mix tables, but only inside blanking, where outputs are zeroed anyway.
- Reset mid-frame: everything returns to reset values immediately. Pending commits and shadow edits are lost.

Decomposition:
- Shared package spr_pkg:
  - DW/SEG_LOG2 defaults
  - a default-breakpoint function default_level(k)
  - a pixel-lane slice helper
- One sub-module, search_idx_lane: the per-channel 2-stage compare/encode/subtract datapath, instantiated CH times in a generate loop.
- The parent owns the shadow/active tables, commit logic and sync delay.

Test Plan:
- Default table, hs=vs=1, pix=63 on all channels -> 2 cycles later idx=0, low=0, high=64, offset=63, span=64.
- Default table, pix=2047 / 1984 / 1983 on ch0/1/2 -> idx=31/31/30; low=1984/1984/1920; high=2047/2047/1984; offset=63/0/63.
- Write the 11-bit legacy levels (0,4,...,44,46,62,...,2046,2047) into shadow mid-frame, pulse cfg_commit:
  - pix=46 still gives idx=0 and pending=1 until i_vs falls;
  - after the fall, pix=46 -> idx=12, low=46, high=62, span=16, pending=0.
- i_hs=0 for 4 cycles with nonzero pixels -> o_hs low for those 4 cycles (2-cycle delayed), all data outputs 0; data resumes the cycle o_hs returns high.
- cfg_commit and cfg_we to addr 5 on the copy cycle -> active[5] keeps the old shadow value, shadow[5] updates, pending=1 again. cfg_addr=SEG+1 write -> no table change.
- Assert rst_n low mid-frame with pending=1 -> all outputs 0 asynchronously, pending=0, table back to defaults after release.
